// File: rtl/ib_lut_pkg.sv
// Shared constants, width helpers and FSM encoding for the IB-VNU LUT page writer
// and the LUT RAM side it feeds.
package ib_lut_pkg;

  localparam int IB_QUAN_SIZE     = 3;
  localparam int IB_LUT_PORT_SIZE = 3;
  localparam int IB_BANK_NUM      = 1;
  localparam int IB_ITER_W        = 5;

  // LUT address width: the table spans two messages (minus the sign bit), MSB picks the half.
  function automatic int entry_addr_of(input int quan_size);
    return $clog2(2 ** (quan_size * 2 - 1));
  endfunction

  function automatic int page_num_of(input int entry_addr);
    return 2 ** (entry_addr - 1);
  endfunction

  localparam int IB_ENTRY_ADDR = entry_addr_of(IB_QUAN_SIZE);
  localparam int IB_DATA_W     = IB_LUT_PORT_SIZE * IB_BANK_NUM;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/ib_lut_page_writer_if.sv
// LUT word stream plus the replicated RAM write bus driven by the page writer.
interface ib_lut_page_writer_if
  import ib_lut_pkg::*;
#(
  parameter int ADDR_W = IB_ENTRY_ADDR,
  parameter int DATA_W = IB_DATA_W
) ();

  logic [DATA_W-1:0] lut_data_in;
  logic              lut_valid;
  logic              lut_ready;

  logic [ADDR_W-1:0] page_addr_ram_replicate_0;
  logic [ADDR_W-1:0] page_addr_ram_replicate_1;
  logic [DATA_W-1:0] ram_write_data_0;
  logic [DATA_W-1:0] ram_write_data_1;
  logic              ib_ram_we;

  // The writer is the master of the RAM banks and consumer of the stream.
  modport master (
    input  lut_data_in, lut_valid,
    output lut_ready,
    output page_addr_ram_replicate_0, page_addr_ram_replicate_1,
    output ram_write_data_0, ram_write_data_1, ib_ram_we
  );

  modport slave (
    output lut_data_in, lut_valid,
    input  lut_ready,
    input  page_addr_ram_replicate_0, page_addr_ram_replicate_1,
    input  ram_write_data_0, ram_write_data_1, ib_ram_we
  );

endinterface

// File: rtl/ib_lut_wr_port_reg.sv
// One registered write port (address/data/enable) toward a LUT RAM replica.
// Address and data hold their last written value while the enable is low.
module ib_lut_wr_port_reg #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              we
);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      data <= '0;
      we   <= 1'b0;
    end else begin
      we <= wr_en;
      if (wr_en) begin
        addr <= wr_addr;
        data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/ib_lut_page_writer.sv
// Write-side master for the IB-VNU LUT RAMs: streams one iteration's LUT contents
// into the inactive half, through two identical registered write ports.
module ib_lut_page_writer
  import ib_lut_pkg::*;
#(
  parameter int QUAN_SIZE     = IB_QUAN_SIZE,
  parameter int LUT_PORT_SIZE = IB_LUT_PORT_SIZE,
  parameter int BANK_NUM      = IB_BANK_NUM,
  parameter int ITER_W        = IB_ITER_W
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  input  logic                  load_start,
  input  logic                  load_half,
  input  logic [ITER_W-1:0]     load_iter_in,
  input  logic                  load_abort,
  ib_lut_page_writer_if.master  bus,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [ITER_W-1:0]     load_iter_out,
  output logic                  err_start_busy
);

  localparam int ENTRY_ADDR = entry_addr_of(QUAN_SIZE);
  localparam int PAGE_NUM   = page_num_of(ENTRY_ADDR);
  localparam int DATA_W     = LUT_PORT_SIZE * BANK_NUM;
  localparam int CNT_W      = ENTRY_ADDR - 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAGE_NUM - 1);

  load_state_e       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              half_q, half_next;
  logic [ITER_W-1:0] tag_q, tag_next;
  logic              accept;
  logic              ready_c;
  logic              err_c;
  logic [1:0]        we_rep;

  // NOTE: defaults first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    half_next  = half_q;
    tag_next   = tag_q;
    ready_c    = 1'b0;
    err_c      = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start && !load_abort) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
          half_next  = load_half;
          tag_next   = load_iter_in;
        end
      end
      ST_LOAD: begin
        ready_c = 1'b1;
        accept  = bus.lut_valid;
        err_c   = load_start;
        if (accept) cnt_next = cnt + 1'b1;
        // Abort wins over completion; a beat accepted alongside it is still written.
        if (load_abort)                   state_next = ST_IDLE;
        else if (accept && cnt == LAST_IDX) state_next = ST_DONE;
      end
      ST_DONE: begin
        err_c      = load_start;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      half_q        <= 1'b0;
      tag_q         <= '0;
      load_iter_out <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      half_q <= half_next;
      tag_q  <= tag_next;
      if (state == ST_LOAD && state_next == ST_DONE) load_iter_out <= tag_q;
    end
  end

  assign bus.lut_ready  = ready_c;
  assign err_start_busy = err_c;
  assign load_busy      = (state != ST_IDLE);
  assign load_done      = (state == ST_DONE);

  ib_lut_wr_port_reg #(.ADDR_W(ENTRY_ADDR), .DATA_W(DATA_W)) u_port_0 (
    .clk     (write_clk),
    .rst_n   (rstn),
    .wr_en   (accept),
    .wr_addr ({half_q, cnt}),
    .wr_data (bus.lut_data_in),
    .addr    (bus.page_addr_ram_replicate_0),
    .data    (bus.ram_write_data_0),
    .we      (we_rep[0])
  );

  ib_lut_wr_port_reg #(.ADDR_W(ENTRY_ADDR), .DATA_W(DATA_W)) u_port_1 (
    .clk     (write_clk),
    .rst_n   (rstn),
    .wr_en   (accept),
    .wr_addr ({half_q, cnt}),
    .wr_data (bus.lut_data_in),
    .addr    (bus.page_addr_ram_replicate_1),
    .data    (bus.ram_write_data_1),
    .we      (we_rep[1])
  );

  // Both replica enables are identical registers; combining them keeps each one live.
  assign bus.ib_ram_we = we_rep[0] & we_rep[1];

endmodule

// File: tb/tb_ib_lut_page_writer.sv
// Directed bench for ib_lut_page_writer: expected RAM writes are queued when a beat
// is driven and compared, cycle-exact, when the write port shows them.
module tb_ib_lut_page_writer;

  logic       write_clk = 1'b0;
  logic       rstn;
  logic       load_start;
  logic       load_half;
  logic [4:0] load_iter_in;
  logic       load_abort;
  logic       load_busy;
  logic       load_done;
  logic [4:0] load_iter_out;
  logic       err_start_busy;

  ib_lut_page_writer_if bus ();

  ib_lut_page_writer dut (
    .write_clk      (write_clk),
    .rstn           (rstn),
    .load_start     (load_start),
    .load_half      (load_half),
    .load_iter_in   (load_iter_in),
    .load_abort     (load_abort),
    .bus            (bus),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_iter_out  (load_iter_out),
    .err_start_busy (err_start_busy)
  );

  always #5 write_clk = ~write_clk;

  typedef struct {
    int         due;
    logic [4:0] addr;
    logic [2:0] data;
    bit         done;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  cycnum = 0;
  int  last_write_cyc = -1;
  int  prev_write_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit valid, input logic [2:0] data, input bit start,
                       input bit half, input logic [4:0] tag, input bit abort);
    bus.lut_valid   = valid;
    bus.lut_data_in = data;
    load_start      = start;
    load_half       = half;
    load_iter_in    = tag;
    load_abort      = abort;
  endtask

  task automatic push(input logic [4:0] addr, input logic [2:0] data, input bit done);
    wr_t w;
    w.due  = cycnum + 1;
    w.addr = addr;
    w.data = data;
    w.done = done;
    sb.push_back(w);
  endtask

  // One clock: compare outputs at the falling edge, then advance past the rising edge.
  task automatic cyc(input bit e_ready, input bit e_busy, input bit e_err);
    bit  e_we;
    bit  e_done;
    wr_t w;
    @(negedge write_clk);
    e_we   = 1'b0;
    e_done = 1'b0;
    if (sb.size() > 0) begin
      if (sb[0].due == cycnum) begin
        e_we   = 1'b1;
        e_done = sb[0].done;
      end
    end
    check("we", bus.ib_ram_we, e_we);
    check("load_done", load_done, e_done);
    check("lut_ready", bus.lut_ready, e_ready);
    check("load_busy", load_busy, e_busy);
    check("err_start_busy", err_start_busy, e_err);
    if (e_we) begin
      w = sb.pop_front();
      check("addr_rep0", bus.page_addr_ram_replicate_0, w.addr);
      check("addr_rep1", bus.page_addr_ram_replicate_1, w.addr);
      check("data_rep0", bus.ram_write_data_0, w.data);
      check("data_rep1", bus.ram_write_data_1, w.data);
    end
    if (bus.ib_ram_we === 1'b1) begin
      prev_write_cyc = last_write_cyc;
      last_write_cyc = cycnum;
    end
    @(posedge write_clk);
    cycnum++;
    #1;
  endtask

  task automatic start(input bit half, input logic [4:0] tag);
    drive(1'b0, 3'd0, 1'b1, half, tag, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [4:0] addr, input logic [2:0] data, input bit last);
    drive(1'b1, data, 1'b0, 1'b0, 5'd0, 1'b0);
    push(addr, data, last);
    cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic gap();
    drive(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic done_step(input bit abort, input bit start_req);
    drive(1'b0, 3'd0, start_req, 1'b1, 5'd31, abort);
    cyc(1'b0, 1'b1, start_req);
  endtask

  task automatic idle(input bit valid);
    drive(valid, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string ctx);
    check({ctx, "_addr0"}, bus.page_addr_ram_replicate_0, 0);
    check({ctx, "_addr1"}, bus.page_addr_ram_replicate_1, 0);
    check({ctx, "_data0"}, bus.ram_write_data_0, 0);
    check({ctx, "_data1"}, bus.ram_write_data_1, 0);
    check({ctx, "_we"}, bus.ib_ram_we, 0);
    check({ctx, "_ready"}, bus.lut_ready, 0);
    check({ctx, "_busy"}, load_busy, 0);
    check({ctx, "_done"}, load_done, 0);
    check({ctx, "_iter_out"}, load_iter_out, 0);
    check({ctx, "_err"}, err_start_busy, 0);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    chk_all_zero("reset");
    #10;
    rstn = 1'b1;
    @(posedge write_clk);
    #1;
    idle(1'b1);

    // Basic load: half 1, tag 7, back-to-back beats; abort during DONE is ignored.
    start(1'b1, 5'd7);
    for (int k = 0; k < 16; k++) beat(5'(16 + k), 3'(k % 8), k == 15);
    done_step(1'b1, 1'b0);
    idle(1'b1);
    check("basic_iter_out", load_iter_out, 7);

    // Stalled stream: valid 1,0,0,1,0,0,... on half 0.
    start(1'b0, 5'd3);
    for (int k = 0; k < 16; k++) begin
      beat(5'(k), 3'((k * 3 + 1) % 8), k == 15);
      if (k < 15) begin
        gap();
        gap();
      end
    end
    done_step(1'b0, 1'b0);
    idle(1'b0);
    check("stall_iter_out", load_iter_out, 3);

    // Busy start during beat 5 and again during DONE: both ignored.
    start(1'b0, 5'd10);
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        drive(1'b1, 3'd5, 1'b1, 1'b1, 5'd20, 1'b0);
        push(5'd5, 3'd5, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
      end else begin
        beat(5'(k), 3'(k % 8), k == 15);
      end
    end
    done_step(1'b0, 1'b1);
    idle(1'b0);
    check("busy_iter_out", load_iter_out, 10);

    // Abort together with the accept of beat 9 on half 1.
    start(1'b1, 5'd12);
    for (int k = 0; k < 9; k++) beat(5'(16 + k), 3'((k + 2) % 8), 1'b0);
    drive(1'b1, 3'd6, 1'b0, 1'b0, 5'd0, 1'b1);
    push(5'd25, 3'd6, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("abort_iter_out", load_iter_out, 10);

    // Abort beats start in IDLE: stays idle.
    drive(1'b0, 3'd0, 1'b1, 1'b1, 5'd9, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // New load on half 0 starts at address 0, then asynchronous reset mid-load.
    start(1'b0, 5'd4);
    beat(5'd0, 3'd3, 1'b0);
    beat(5'd1, 3'd4, 1'b0);
    beat(5'd2, 3'd7, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    sb.delete();
    chk_all_zero("async_rst");
    drive(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge write_clk);
    #3;
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Back-to-back loads: second start in the IDLE cycle right after DONE.
    start(1'b1, 5'd5);
    for (int k = 0; k < 16; k++) beat(5'(16 + k), 3'((k * 5) % 8), k == 15);
    done_step(1'b0, 1'b0);
    start(1'b0, 5'd6);
    for (int k = 0; k < 16; k++) begin
      beat(5'(k), 3'((k + 5) % 8), k == 15);
      if (k == 1) check("b2b_gap", last_write_cyc - prev_write_cyc - 1, 2);
    end
    done_step(1'b0, 1'b0);
    idle(1'b0);
    check("b2b_iter_out", load_iter_out, 6);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ib_lut_page_writer.md
Name: ib_lut_page_writer

Overview:
- Write-side master for the IB-VNU LUT RAMs read by the partial-VNU datapaths.
- Accepts one iteration's LUT contents as a valid/ready stream from the iteration-update controller.
- Drives page_addr_ram_replicate_0/1, ram_write_data_0/1 and ib_ram_we into the VNU/DNU LUT banks.
- Fills the inactive RAM half (address MSB = write offset) while readers use the other half.

Parameters:
- QUAN_SIZE, 3, message quantisation width (bits).
- ENTRY_ADDR, 5, LUT address width. Equals $clog2(2**(QUAN_SIZE*2-1)). The MSB is the half/offset bit.
- LUT_PORT_SIZE, 3, LUT data word width.
- BANK_NUM, 1, number of banks per write port.
- ITER_W, 5, width of the iteration tag.
- PAGE_NUM, 2**(ENTRY_ADDR-1) = 16, entries per half (derived, localparam).

Ports:
- write_clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle request to load one half.
- load_half  in  1  target half, sampled with load_start.
- load_iter_in  in  ITER_W  iteration tag, sampled with load_start.
- load_abort  in  1  synchronous abort.
- lut_data_in  in  LUT_PORT_SIZE*BANK_NUM  LUT word stream.
- lut_valid  in  1  stream valid.
- lut_ready  out  1  stream ready.
- page_addr_ram_replicate_0  out  ENTRY_ADDR  write address, replica 0.
- page_addr_ram_replicate_1  out  ENTRY_ADDR  write address, replica 1.
- ram_write_data_0  out  LUT_PORT_SIZE*BANK_NUM  write data, replica 0.
- ram_write_data_1  out  LUT_PORT_SIZE*BANK_NUM  write data, replica 1.
- ib_ram_we  out  1  write enable, shared by both replicas.
- load_busy  out  1  high while not IDLE.
- load_done  out  1  one-cycle pulse when a half is fully written.
- load_iter_out  out  ITER_W  tag of the last completed load.
- err_start_busy  out  1  one-cycle pulse when load_start is ignored.

Behaviour:
- Reset (rstn low, asynchronous):
  - State = IDLE; page counter = 0.
  - All outputs 0: addresses, data, ib_ram_we, lut_ready, load_busy, load_done, load_iter_out, err_start_busy.
  - Reset mid-load leaves the RAM half partially written; no load_done is issued.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - lut_ready = 0.
  - load_start = 1 → capture load_half and load_iter_in, clear the counter, go to LOAD.
- LOAD:
  - lut_ready = 1, combinational from state only.
  - A beat is accepted when lut_valid & lut_ready.
  - An accepted beat with counter = k writes on the next edge: ib_ram_we = 1, both addresses = {half, k[ENTRY_ADDR-2:0]}, both data outputs = lut_data_in. Replicas are always identical, and each replica is a separate register for fanout.
  - Counter increments per accepted beat.
  - The accept at k = PAGE_NUM-1 moves the state to DONE. The counter wraps to 0.
  - A cycle with no beat gives ib_ram_we = 0 next cycle. Address/data registers hold their values.
- DONE (exactly one cycle):
  - The last write is visible (ib_ram_we = 1).
  - load_done = 1; load_iter_out updated to the captured tag.
  - Next state IDLE.
- Write latency: exactly 1 cycle from acceptance to ib_ram_we.
- Back-to-back loads: the earliest next load_start is honoured in the IDLE cycle after DONE.
- load_start while in LOAD or DONE:
  - Ignored; err_start_busy pulses 1 cycle.
  - Captured half/tag are unchanged.
- load_abort:
  - In LOAD → IDLE next cycle. A beat accepted in the same cycle is still written. No load_done.
  - In DONE → ignored (load completes normally).
  - In IDLE → no effect.
  - load_abort has priority over load_start in the same cycle.
- lut_valid while not in LOAD: not accepted, no write.
- The block never writes the half not selected for the current load.

Decomposition:
- Shared package (ib_lut_pkg):
  - ENTRY_ADDR and PAGE_NUM derivation.
  - FSM state encoding (2-bit: IDLE = 0, LOAD = 1, DONE = 2).
  - Width localparams shared with the LUT RAM side.
- One natural sub-module, ib_lut_wr_port_reg: a registered address/data/we stage, instantiated twice (one per replica).
- FSM and counter stay in the top level.

Test Plan:
- Basic load: load_half = 1, tag = 7, 16 back-to-back beats with data = k mod 8.
  - Writes to addresses 16..31 with data 0..7,0..7, one per cycle, starting one cycle after each accept.
  - load_done in the cycle of the address-31 write; load_iter_out = 7; replica 0 equals replica 1 every cycle.
- Stalled stream: load_half = 0, lut_valid toggled 1,0,0,1,...
  - ib_ram_we is high only the cycle after each accept.
  - Addresses run 0..15 in order with no gaps and no duplicates.
- Busy start: load_start during beat 5 of a load.
  - err_start_busy pulses once; target half and tag are unchanged; the load completes at address 15.
- Abort: load_abort asserted in the same cycle as the accept of beat 9 (half 1).
  - Beat 9 is written to address 25; no further writes; no load_done.
  - A new start with half 0 then writes from address 0.
- Async reset: rstn low mid-load, asynchronous to the clock edge.
  - All outputs 0 immediately; after release the block is in IDLE with lut_ready = 0.
- Back-to-back: second load_start in the IDLE cycle after DONE.
  - Second load accepted; total gap between the last write of load 1 and the first write of load 2 is 2 cycles.
